// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift unit.
//   mode_e  : operation select carried on the 2-bit mode port
//             (arithmetic, logical, rotate, reserved/pass-through)
//   state_e : control states of the shift unit sequencer
// ---------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_ARITH = 2'b00,
        MODE_LOGIC = 2'b01,
        MODE_ROT   = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single step of the iterative shifter: moves a value by
// 0..STEP bit positions in one direction for a given mode.
//   value_i : value before this step
//   count_i : positions to move this step (0..STEP)
//   left_i  : 1 = shift/rotate left, 0 = right
//   mode_i  : arithmetic, logical, rotate or reserved
//   carry_i : carry held from the previous step (kept when nothing moves)
//   value_o : value after this step
//   carry_o : last bit pushed out of (or around) the word by this step
// ---------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0]       value_i,
    input  logic [$clog2(STEP):0]  count_i,
    input  logic                   left_i,
    input  mode_e                  mode_i,
    input  logic                   carry_i,
    output logic [WIDTH-1:0]       value_o,
    output logic                   carry_o
);

    int moveCount;

    // One step of the shift. Left shifts always fill with zero, so only the
    // right direction distinguishes arithmetic from logical. The carry is
    // the last bit to leave the word: bit WIDTH-n when going left and bit
    // n-1 when going right. For rotates that same bit reappears at the far
    // end, which is exactly what the carry must report.
    always_comb begin
        moveCount = int'(count_i);
        value_o   = value_i;
        carry_o   = carry_i;

        if (moveCount != 0 && mode_i != MODE_RSVD) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (left_i && (i == WIDTH - moveCount)) begin
                    carry_o = value_i[i];
                end
                if (!left_i && (i == moveCount - 1)) begin
                    carry_o = value_i[i];
                end
            end

            if (left_i) begin
                if (mode_i == MODE_ROT) begin
                    value_o = (value_i << moveCount) | (value_i >> (WIDTH - moveCount));
                end else begin
                    value_o = value_i << moveCount;
                end
            end else begin
                case (mode_i)
                    MODE_ARITH: value_o = $signed(value_i) >>> moveCount;
                    MODE_ROT:   value_o = (value_i >> moveCount) | (value_i << (WIDTH - moveCount));
                    default:    value_o = value_i >> moveCount;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
// Iterative barrel-shift replacement: accepts one request, moves it at most
// STEP positions per cycle through a single shift_step instance, then holds
// the result until the consumer takes it.
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous active-high reset
//   in_valid  : request present          in_ready  : accepting (IDLE only)
//   src       : signed operand           amount    : signed count (+left/-right)
//   mode      : 00 arith, 01 logic, 10 rotate, 11 pass-through
//   out_valid : result present (DONE)    out_ready : consumer takes result
//   result    : shifted value            carry     : last bit moved out
//   zero      : result equals zero
// ---------------------------------------------------------------------------
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     src,
    input  logic signed [$clog2(WIDTH):0] amount,
    input  logic [1:0]                  mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH-1:0]     result,
    output logic                        carry,
    output logic                        zero
);

    localparam int AW = $clog2(WIDTH) + 1;
    localparam int CW = $clog2(STEP) + 1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              carry_q, carry_d;
    logic [AW-1:0]     remain_q, remain_d;
    logic              left_q, left_d;
    mode_e             mode_q, mode_d;

    logic [AW-1:0]     amountRaw;
    logic [AW-1:0]     amountMag;
    logic [CW-1:0]     stepCount;
    logic [WIDTH-1:0]  stepValue;
    logic              stepCarry;

    // The count arrives two's-complement; the datapath only needs its
    // magnitude plus a direction flag. The most negative count (-WIDTH)
    // still fits because the magnitude register has the same width.
    assign amountRaw = amount;
    assign amountMag = amountRaw[AW-1] ? (AW'(0) - amountRaw) : amountRaw;

    // Each SHIFT cycle moves the full STEP unless fewer positions remain.
    assign stepCount = (remain_q > AW'(STEP)) ? CW'(STEP) : CW'(remain_q);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .value_i (data_q),
        .count_i (stepCount),
        .left_i  (left_q),
        .mode_i  (mode_q),
        .carry_i (carry_q),
        .value_o (stepValue),
        .carry_o (stepCarry)
    );

    // State and datapath registers. Reset clears everything, discarding any
    // operation in flight, and wins over every handshake input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            carry_q  <= 1'b0;
            remain_q <= '0;
            left_q   <= 1'b0;
            mode_q   <= MODE_ARITH;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            carry_q  <= carry_d;
            remain_q <= remain_d;
            left_q   <= left_d;
            mode_q   <= mode_d;
        end
    end

    // Next-state logic. Operands are captured only in IDLE, so anything on
    // the inputs while busy is ignored. A zero count or the reserved mode
    // skips SHIFT entirely and presents src unchanged with carry cleared.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        carry_d  = carry_q;
        remain_d = remain_q;
        left_d   = left_q;
        mode_d   = mode_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d   = src;
                    carry_d  = 1'b0;
                    remain_d = amountMag;
                    left_d   = ~amountRaw[AW-1];
                    mode_d   = mode_e'(mode);
                    if (amountMag == '0 || mode == MODE_RSVD) begin
                        remain_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d   = stepValue;
                carry_d  = stepCarry;
                remain_d = remain_q - AW'(stepCount);
                if (remain_q <= AW'(STEP)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = data_q;
    assign carry     = carry_q;
    assign zero      = (data_q == '0);

endmodule

// File: tb/tb_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_unit
// Self-checking bench for shift_unit (WIDTH=16, STEP=4): directed cases
// followed by randomized requests compared against a bit-level reference.
// ---------------------------------------------------------------------------
module tb_shift_unit;

    localparam int W    = 16;
    localparam int STEP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  src;
    logic [4:0]    amount;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry;
    logic          zero;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    shift_unit #(
        .WIDTH (W),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src       (src),
        .amount    (amount),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    // Reference: each result bit is picked from its source position, with
    // out-of-range positions taking the fill bit; rotates wrap modulo W.
    function automatic void modelOp(input logic [W-1:0] s, input int amt, input int md,
                                    output logic [W-1:0] r, output logic c, output int lat);
        int  n;
        int  j;
        int  e;
        logic fill;
        bit  left;
        n    = (amt < 0) ? -amt : amt;
        left = (amt > 0);
        r    = s;
        c    = 1'b0;
        lat  = 1;
        if (md != 3 && n != 0) begin
            lat = 1 + (n + STEP - 1) / STEP;
            if (md == 2) begin
                e = n % W;
                for (int i = 0; i < W; i++) begin
                    r[i] = left ? s[(i - e + W) % W] : s[(i + e) % W];
                end
                c = left ? r[0] : r[W-1];
            end else begin
                fill = (md == 0 && !left) ? s[W-1] : 1'b0;
                for (int i = 0; i < W; i++) begin
                    j    = left ? i - n : i + n;
                    r[i] = (j >= 0 && j < W) ? s[j] : fill;
                end
                c = left ? s[W-n] : s[n-1];
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd1);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_result"},    32'(result),    32'd0);
        checkOutput({tag, "_carry"},     32'(carry),     32'd0);
        checkOutput({tag, "_zero"},      32'(zero),      32'd1);
    endtask

    // One complete request: present it, count edges to out_valid, check the
    // result, hold it under backpressure for 'hold' cycles, then release.
    task automatic applyStimulus(input logic [W-1:0] s, input int amt, input int md,
                                 input int hold, input bit noise);
        logic [W-1:0] expR;
        logic         expC;
        int           expLat;
        int           lat;
        modelOp(s, amt, md, expR, expC, expLat);
        checkOutput("in_ready_before", 32'(in_ready), 32'd1);
        src       = s;
        amount    = 5'(amt);
        mode      = 2'(md);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                src    = W'($urandom);
                amount = 5'($urandom);
                mode   = 2'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        checkOutput("latency",  32'(lat),      32'(expLat));
        checkOutput("result",   32'(result),   32'(expR));
        checkOutput("carry",    32'(carry),    32'(expC));
        checkOutput("zero",     32'(zero),     32'(expR == '0));
        checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            in_valid = (k % 2 == 0);
            src      = W'($urandom);
            amount   = 5'($urandom);
            @(posedge clk); #1;
            checkOutput("hold_result",    32'(result),    32'(expR));
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("release_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        int rAmt;
        reset     = 1'b1;
        in_valid  = 1'b1;
        src       = 16'hFFFF;
        amount    = 5'd3;
        mode      = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        checkIdle("reset");

        applyStimulus(16'h8001,   1, 1, 0, 0);
        applyStimulus(16'h8001,  -3, 0, 1, 0);
        applyStimulus(16'h1234,  -4, 2, 0, 0);
        applyStimulus(16'h1234,  10, 2, 0, 0);
        applyStimulus(16'h8000, -16, 0, 0, 0);
        applyStimulus(16'h8000, -16, 1, 0, 0);
        applyStimulus(16'h8000,   0, 0, 0, 0);
        applyStimulus(16'hBEEF,   7, 3, 0, 0);
        applyStimulus(16'h00F0, -16, 2, 0, 0);
        applyStimulus(16'h0F0F,   5, 0, 5, 1);

        src      = 16'hABCD;
        amount   = 5'd15;
        mode     = 2'b01;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkIdle("midop_reset");
        applyStimulus(16'hABCD, 15, 1, 0, 0);

        for (int t = 0; t < 150; t++) begin
            rAmt = int'($urandom_range(0, 31)) - 16;
            applyStimulus(W'($urandom), rAmt, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data width in bits (power of two, >= 8).
REQ-002 SHALL have parameter STEP, default 4, meaning maximum bit positions moved per SHIFT cycle (power of two, 1..WIDTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL have port src  input  WIDTH  signed operand.
REQ-008 SHALL have port amount  input  $clog2(WIDTH)+1  signed shift count: positive = left, negative = right, zero = pass-through.
REQ-009 SHALL have port mode  input  2  operation select: 00 arithmetic, 01 logical, 10 rotate, 11 reserved.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  WIDTH  signed shifted value.
REQ-013 SHALL have port carry  output  1  last bit shifted or rotated out.
REQ-014 SHALL have port zero  output  1  result equals 0.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, when in_valid is 1, the unit SHALL capture src, |amount|, the direction and mode, then go to DONE if amount == 0, otherwise to SHIFT.
REQ-018 In SHIFT, each cycle SHALL move min(remaining, STEP) positions and decrement remaining by that count; when remaining reaches 0, the unit SHALL go to DONE.
REQ-019 If acceptance occurs at edge k, out_valid SHALL rise after edge k+1 for amount 0, and after edge k+1+ceil(|amount|/STEP) otherwise.
REQ-020 In DONE, result, carry and zero SHALL hold stable until out_ready is 1; the unit SHALL then go to IDLE, so a new request is accepted no earlier than the following cycle.
REQ-021 Logical left and arithmetic left SHALL fill with 0; logical right SHALL fill with 0; arithmetic right SHALL fill with the sign bit.
REQ-022 Rotate SHALL move bits circularly, with the effective count equal to |amount| mod WIDTH.
REQ-023 A left or right count of magnitude WIDTH (amount = -WIDTH) in non-rotate modes SHALL produce all fill bits, with carry = the last bit out.
REQ-024 carry SHALL be 0 for amount 0.
REQ-025 For rotate, carry SHALL equal result[WIDTH-1] after a right rotate and result[0] after a left rotate.
REQ-026 mode 11 SHALL behave as pass-through (result = src, carry = 0) with amount-0 latency.
REQ-027 zero SHALL be combinational from the result register.
REQ-028 Inputs SHALL be ignored outside the acceptance cycle.
REQ-029 in_valid held high while the unit is busy SHALL NOT alter the in-flight operation.

Reset
REQ-030 While reset is 1 at a rising edge, the state SHALL become IDLE; result, carry and the remaining count SHALL be cleared to 0; and an in-flight operation SHALL be discarded.
REQ-031 After reset, the outputs SHALL read in_ready=1, out_valid=0, result=0, carry=0, zero=1.
REQ-032 Reset SHALL have priority over every handshake input in the same cycle.

Structure
REQ-033 Package shift_pkg SHALL hold the mode encodings (MODE_ARITH, MODE_LOGIC, MODE_ROT, MODE_RSVD) and the FSM state typedef.
REQ-034 A combinational sub-module shift_step SHALL perform one step of 0..STEP positions for a given direction and mode, returning the next value and carry; shift_unit SHALL instantiate it once.

Verification
REQ-035 Reset and throughput, WIDTH=16, STEP=4: after reset, src=16'h8001, amount=+1, mode=01, out_ready=1 -> result 16'h0002, carry 1, out_valid two cycles after acceptance.
REQ-036 Sign fill and latency: src=16'h8001, amount=-3, mode=00 -> result 16'hF000, carry 0, zero 0, one SHIFT cycle.
REQ-037 Rotate and multi-cycle: src=16'h1234, amount=-4, mode=10 -> result 16'h4123, carry 0; amount=+10 -> 3 SHIFT cycles, result 16'hD048.
REQ-038 Boundary: src=16'h8000, amount=-16, mode=00 -> 16'hFFFF, carry 1; same with mode=01 -> 16'h0000, carry 1, zero 1; amount=0 -> result=src, carry 0, latency 1.
REQ-039 Backpressure: out_ready held 0 for 5 cycles in DONE -> result stable and in_ready 0 throughout; in_valid pulses in that window are ignored.
REQ-040 Reset mid-operation: assert reset during SHIFT of amount=+15 -> next cycle shows IDLE outputs per REQ-031, and a subsequent request completes correctly.
